// File: rtl/prime_detector_seq.sv
// Iterative prime tester: classifies trivial operands, then runs a bit-pair square root
// and odd trial division on a shift-subtract divider. Results also drive the display digit.
module prime_detector_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] test_number,
    output logic             busy,
    output logic             done,
    output logic             is_prime,
    output logic [WIDTH-1:0] smallest_factor,
    output logic [3:0]       digit,
    output logic             stop_counter
);
    localparam int H  = WIDTH / 2;
    localparam int DW = H + 2;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] SQ_LAST  = CW'(H - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, CLASSIFY, SQRT, TEST, DIV, EVAL
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]  n_reg;
    logic [WIDTH-1:0]  sq_shift;
    logic [H+2:0]      sq_rem;
    logic [H-1:0]      root;
    logic [DW-1:0]     d;
    logic [WIDTH:0]    dv_rem;
    logic [WIDTH-1:0]  dv_shift;
    logic [CW-1:0]     cnt;

    logic              fin;
    logic              fin_prime;
    logic [WIDTH-1:0]  fin_factor;

    logic [H+2:0]      sq_shifted;
    logic [H+2:0]      sq_rem_new;
    logic [WIDTH:0]    dv_partial;
    logic [WIDTH:0]    dv_trial;
    logic [WIDTH:0]    dv_rem_new;

    assign busy = (state != IDLE);

    // Non-restoring root step: the sign of the partial remainder picks add or subtract
    // and directly yields the next root bit, so no correction pass is needed.
    always_comb begin
        sq_shifted = {sq_rem[H:0], sq_shift[WIDTH-1:WIDTH-2]};
        if (sq_rem[H+2])
            sq_rem_new = sq_shifted + {1'b0, root, 2'b11};
        else
            sq_rem_new = sq_shifted - {1'b0, root, 2'b01};
        dv_partial = {dv_rem[WIDTH-1:0], dv_shift[WIDTH-1]};
        dv_trial   = dv_partial - {{(WIDTH+1-DW){1'b0}}, d};
        dv_rem_new = dv_trial[WIDTH] ? dv_partial : dv_trial;
    end

    always_comb begin
        state_next = state;
        fin        = 1'b0;
        fin_prime  = 1'b0;
        fin_factor = '0;
        case (state)
            IDLE: begin
                if (start)
                    state_next = CLASSIFY;
            end
            CLASSIFY: begin
                if (n_reg < WIDTH'(2)) begin
                    fin = 1'b1;
                end else if (!n_reg[0]) begin
                    fin        = 1'b1;
                    fin_prime  = (n_reg == WIDTH'(2));
                    fin_factor = WIDTH'(2);
                end else begin
                    state_next = SQRT;
                end
            end
            SQRT: begin
                if (cnt == SQ_LAST)
                    state_next = TEST;
            end
            TEST: begin
                if (d > {2'b00, root}) begin
                    fin        = 1'b1;
                    fin_prime  = 1'b1;
                    fin_factor = n_reg;
                end else begin
                    state_next = DIV;
                end
            end
            DIV: begin
                if (cnt == DIV_LAST)
                    state_next = EVAL;
            end
            EVAL: begin
                if (dv_rem == '0) begin
                    fin                = 1'b1;
                    fin_factor[DW-1:0] = d;
                end else begin
                    state_next = TEST;
                end
            end
            default: state_next = IDLE;
        endcase
        if (fin)
            state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            done            <= 1'b0;
            is_prime        <= 1'b0;
            smallest_factor <= '0;
            digit           <= 4'hC;
            stop_counter    <= 1'b0;
            n_reg           <= '0;
            sq_shift        <= '0;
            sq_rem          <= '0;
            root            <= '0;
            d               <= '0;
            dv_rem          <= '0;
            dv_shift        <= '0;
            cnt             <= '0;
        end else begin
            state <= state_next;
            done  <= fin;
            if (fin) begin
                is_prime        <= fin_prime;
                smallest_factor <= fin_factor;
                digit           <= fin_prime ? 4'h1 : 4'h0;
                stop_counter    <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        n_reg        <= test_number;
                        stop_counter <= 1'b0;
                        digit        <= 4'hC;
                    end
                end
                CLASSIFY: begin
                    sq_shift <= n_reg;
                    sq_rem   <= '0;
                    root     <= '0;
                    cnt      <= '0;
                    d        <= DW'(3);
                end
                SQRT: begin
                    sq_shift <= {sq_shift[WIDTH-3:0], 2'b00};
                    sq_rem   <= sq_rem_new;
                    root     <= {root[H-2:0], ~sq_rem_new[H+2]};
                    cnt      <= cnt + 1'b1;
                end
                TEST: begin
                    dv_rem   <= '0;
                    dv_shift <= n_reg;
                    cnt      <= '0;
                end
                DIV: begin
                    dv_rem   <= dv_rem_new;
                    dv_shift <= {dv_shift[WIDTH-2:0], 1'b0};
                    cnt      <= cnt + 1'b1;
                end
                EVAL: begin
                    d <= d + DW'(2);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_prime_detector_seq.sv
// Scoreboarded bench for prime_detector_seq at WIDTH=8: directed corner operands plus
// random operands, junk starts while busy, and a mid-operation reset.
module tb_prime_detector_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] test_number = '0;
    logic         busy, done, is_prime, stop_counter;
    logic [W-1:0] smallest_factor;
    logic [3:0]   digit;

    typedef struct {
        int n;
        int prime;
        int factor;
        int lat;
        int accept;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;
    int   cycle = 0;
    bit   inflight_bad = 0;

    prime_detector_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .test_number(test_number),
        .busy(busy), .done(done), .is_prime(is_prime),
        .smallest_factor(smallest_factor), .digit(digit), .stop_counter(stop_counter)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input int actual, input int required);
        compared++;
        if (actual != required) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, required, cycle);
        end
    endtask

    // Reference: direct trial division with %, plus latency from the number of failed trials.
    function automatic exp_t model(input int n);
        exp_t e;
        int r, trials;
        e.n = n; e.accept = 0;
        if (n < 2) begin
            e.prime = 0; e.factor = 0; e.lat = 2;
        end else if (n % 2 == 0) begin
            e.prime = (n == 2); e.factor = 2; e.lat = 2;
        end else begin
            r = 0;
            while ((r + 1) * (r + 1) <= n) r++;
            e.prime = 1; e.factor = n; trials = 0;
            for (int dd = 3; dd <= r; dd += 2) begin
                if (n % dd == 0) begin
                    e.prime = 0; e.factor = dd;
                    break;
                end
                trials++;
            end
            e.lat = e.prime ? (W/2 + 3 + trials*(W+2)) : (W/2 + 2 + trials*(W+2) + W + 2);
        end
        return e;
    endfunction

    task automatic applyStimulus(input int n);
        exp_t e;
        int   waited = 0;
        forever begin
            @(posedge clk); #1;
            if (!busy) break;
            start = 1'($urandom_range(0, 1));
            test_number = W'($urandom);
            waited++;
            if (waited > 2000) begin
                checkOutput("idle_timeout", 0, 1);
                start = 1'b0;
                sb.delete();
                return;
            end
        end
        start = 1'b1;
        test_number = W'(n);
        e = model(n);
        e.accept = cycle;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        test_number = W'($urandom);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput($sformatf("latency_n%0d", e.n), cycle - e.accept, e.lat);
                    checkOutput($sformatf("is_prime_n%0d", e.n), int'(is_prime), e.prime);
                    checkOutput($sformatf("factor_n%0d", e.n), int'(smallest_factor), e.factor);
                    checkOutput($sformatf("digit_n%0d", e.n), int'(digit), e.prime);
                    checkOutput($sformatf("stop_n%0d", e.n), int'(stop_counter), 1);
                    checkOutput($sformatf("busy_at_done_n%0d", e.n), int'(busy), 0);
                    checkOutput($sformatf("busy_digit_inflight_n%0d", e.n), int'(inflight_bad), 0);
                    inflight_bad = 0;
                end
            end else if (sb.size() > 0 && cycle > sb[0].accept) begin
                if (!busy || digit != 4'hC || stop_counter) inflight_bad = 1;
            end
        end
    end

    initial begin
        int directed[$] = '{97, 91, 0, 1, 2, 8, 3, 255, 251, 4, 9, 25, 49, 121, 169, 225, 143};
        int waited;

        start = 1'b1;
        test_number = W'(5);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy_with_start", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_is_prime", int'(is_prime), 0);
        checkOutput("reset_factor", int'(smallest_factor), 0);
        checkOutput("reset_digit", int'(digit), 'hC);
        checkOutput("reset_stop", int'(stop_counter), 0);
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (directed[i]) applyStimulus(directed[i]);

        // Abort a long prime test mid-flight; no done may follow.
        applyStimulus(97);
        repeat (18) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        inflight_bad = 0;
        @(negedge clk);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_digit", int'(digit), 'hC);
        checkOutput("abort_stop", int'(stop_counter), 0);
        checkOutput("abort_done", int'(done), 0);
        checkOutput("abort_factor", int'(smallest_factor), 0);
        repeat (80) @(posedge clk);
        applyStimulus(221);

        for (int i = 0; i < 150; i++) applyStimulus(int'($urandom_range(0, (1 << W) - 1)));

        waited = 0;
        while (sb.size() > 0 && waited < 2000) begin
            @(posedge clk);
            waited++;
        end
        if (sb.size() > 0) checkOutput("final_drain_timeout", sb.size(), 0);
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
